coax_link_supervisor: RTL

//  Link bring-up/recovery controller for the SPI-coax receive path, in the clk_sys domain.

---
 rtl/coax_link_supervisor_pkg.sv | 20 ++
 rtl/coax_link_supervisor_if.sv | 33 +++
 rtl/coax_link_supervisor_err_window.sv | 53 +++++
 rtl/coax_link_supervisor.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/coax_link_supervisor_pkg.sv
// Shared types and default constants for the SPI-coax link supervisor.
package coax_sup_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_ACTIVE    = 3'd3,
    ST_FAULT     = 3'd4
  } sup_state_e;

  localparam int DEF_RST_CYCLES   = 16;
  localparam int DEF_LOCK_STABLE  = 64;
  localparam int DEF_LOCK_TIMEOUT = 4096;
  localparam int DEF_ERR_WINDOW   = 1024;
  localparam int DEF_ERR_THRESH   = 8;
  localparam int DEF_MAX_RETRIES  = 3;
  localparam int DEF_CNT_W        = 32;

endpackage

// File: rtl/coax_link_supervisor_if.sv
// Control/status bundle between the system side and the link supervisor.
// master: the system/controller side; slave: the supervisor itself.
interface coax_link_supervisor_if #(
  parameter int CNT_W = 32
);
  logic             enable;
  logic             cdr_locked;
  logic             rx_valid;
  logic             frame_error;
  logic             sync_lost;
  logic             stats_clr;
  logic             link_rst_n;
  logic             link_enable;
  logic             link_up;
  logic             fault;
  logic [2:0]       state_o;
  logic [1:0]       retry_cnt;
  logic [CNT_W-1:0] frames_ok;
  logic [CNT_W-1:0] frames_err;
  logic [CNT_W-1:0] retrains;

  modport master (
    output enable, cdr_locked, rx_valid, frame_error, sync_lost, stats_clr,
    input  link_rst_n, link_enable, link_up, fault, state_o, retry_cnt,
           frames_ok, frames_err, retrains
  );

  modport slave (
    input  enable, cdr_locked, rx_valid, frame_error, sync_lost, stats_clr,
    output link_rst_n, link_enable, link_up, fault, state_o, retry_cnt,
           frames_ok, frames_err, retrains
  );
endinterface

// File: rtl/coax_link_supervisor_err_window.sv
// Frame-error observation window: a free-running window counter plus a
// saturating error counter. thresh_hit flags the cycle whose error brings the
// count of the current window up to ERR_THRESH. An error in the wrap cycle
// is the first error of the new window.
module sup_err_window
  import coax_sup_pkg::*;
#(
  parameter int ERR_WINDOW = DEF_ERR_WINDOW,
  parameter int ERR_THRESH = DEF_ERR_THRESH
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic clear,
  input  logic err,
  output logic thresh_hit
);
  localparam int WIN_W  = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
  localparam int ECNT_W = $clog2(ERR_THRESH + 1);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(ERR_WINDOW - 1);
  localparam logic [ECNT_W-1:0] THRESH   = ECNT_W'(ERR_THRESH);

  logic [WIN_W-1:0]  win_cnt;
  logic [ECNT_W-1:0] err_cnt;
  logic [ECNT_W-1:0] err_cnt_nxt;
  logic              wrap;

  function automatic logic [ECNT_W-1:0] sat_err_inc(input logic [ECNT_W-1:0] base,
                                                    input logic inc);
    if (inc && (base != THRESH)) return base + 1'b1;
    return base;
  endfunction

  // Window wrap detection and next error count
  always_comb begin
    wrap        = (win_cnt == WIN_LAST);
    err_cnt_nxt = sat_err_inc(wrap ? '0 : err_cnt, err);
    thresh_hit  = err && (err_cnt_nxt == THRESH);
  end

  // Window and error counters, held at zero while cleared
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
      err_cnt <= '0;
    end else if (clear) begin
      win_cnt <= '0;
      err_cnt <= '0;
    end else begin
      win_cnt <= wrap ? '0 : win_cnt + 1'b1;
      err_cnt <= err_cnt_nxt;
    end
  end
endmodule

// File: rtl/coax_link_supervisor.sv
// Link bring-up/recovery supervisor for the SPI-coax receive path (clk_sys).
// Sequences reset -> CDR lock -> active, retrains on degradation, and latches
// a fault after MAX_RETRIES consecutive failed attempts.
// Optional build macro SUP_STATS_EN adds saturating frame/retrain statistics;
// without it the statistics outputs are constant zero.
module coax_link_supervisor
  import coax_sup_pkg::*;
#(
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int ERR_WINDOW   = DEF_ERR_WINDOW,
  parameter int ERR_THRESH   = DEF_ERR_THRESH,
  parameter int MAX_RETRIES  = DEF_MAX_RETRIES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input logic                   clk_sys,
  input logic                   rst_n,
  coax_link_supervisor_if.slave sup
);
  localparam int TMR_W = $clog2(LOCK_TIMEOUT + RST_CYCLES + 1);
  localparam int STB_W = $clog2(LOCK_STABLE + 1);
  localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST  = STB_W'(LOCK_STABLE - 1);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRIES);

  sup_state_e       state, state_nxt;
  logic [1:0]       retry_q, retry_nxt;
  logic [TMR_W-1:0] tmr;
  logic [STB_W-1:0] stable_cnt;
  logic             lock_done, tmo_hit, err_strobe, thresh_hit, degrade, win_clear;
  logic             link_rst_n_nxt, link_enable_nxt, link_up_nxt, fault_nxt;

  assign lock_done  = sup.cdr_locked && (stable_cnt == STB_LAST);
  assign tmo_hit    = (tmr == TMO_LAST);
  assign err_strobe = (state == ST_ACTIVE) && sup.rx_valid && sup.frame_error;
  assign win_clear  = (state != ST_ACTIVE);
  assign degrade    = thresh_hit || sup.sync_lost || !sup.cdr_locked;

  sup_err_window #(
    .ERR_WINDOW (ERR_WINDOW),
    .ERR_THRESH (ERR_THRESH)
  ) u_err_window (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .clear      (win_clear),
    .err        (err_strobe),
    .thresh_hit (thresh_hit)
  );

  // State and retry registers
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      retry_q <= '0;
    end else begin
      state   <= state_nxt;
      retry_q <= retry_nxt;
    end
  end

  // Next-state decision; lock beats timeout, disable beats everything
  always_comb begin
    logic attempt_fail;
    attempt_fail = 1'b0;
    state_nxt    = state;
    retry_nxt    = retry_q;
    case (state)
      ST_IDLE:      if (sup.enable) state_nxt = ST_RESET;
      ST_RESET:     if (tmr == RST_LAST) state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_done) begin
          state_nxt = ST_ACTIVE;
          retry_nxt = '0;
        end else if (tmo_hit) begin
          attempt_fail = 1'b1;
        end
      end
      ST_ACTIVE:    if (degrade) attempt_fail = 1'b1;
      ST_FAULT:     state_nxt = ST_FAULT;
      default:      state_nxt = ST_IDLE;
    endcase
    if (attempt_fail) begin
      retry_nxt = retry_q + 1'b1;
      state_nxt = (retry_nxt == RETRY_MAX) ? ST_FAULT : ST_RESET;
    end
    if (!sup.enable) begin
      state_nxt = ST_IDLE;
      retry_nxt = '0;
    end
  end

  // Output decode of the upcoming state so the registered outputs track it
  always_comb begin
    link_rst_n_nxt  = 1'b0;
    link_enable_nxt = 1'b0;
    link_up_nxt     = 1'b0;
    fault_nxt       = 1'b0;
    case (state_nxt)
      ST_WAIT_LOCK: begin
        link_rst_n_nxt  = 1'b1;
        link_enable_nxt = 1'b1;
      end
      ST_ACTIVE: begin
        link_rst_n_nxt  = 1'b1;
        link_enable_nxt = 1'b1;
        link_up_nxt     = 1'b1;
      end
      ST_FAULT: fault_nxt = 1'b1;
      default: ;
    endcase
  end

  // Registered link control outputs
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sup.link_rst_n  <= 1'b0;
      sup.link_enable <= 1'b0;
      sup.link_up     <= 1'b0;
      sup.fault       <= 1'b0;
    end else begin
      sup.link_rst_n  <= link_rst_n_nxt;
      sup.link_enable <= link_enable_nxt;
      sup.link_up     <= link_up_nxt;
      sup.fault       <= fault_nxt;
    end
  end

  // Phase timer (reset length / lock timeout) and consecutive-lock counter
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      tmr        <= '0;
      stable_cnt <= '0;
    end else begin
      if (state_nxt != state) tmr <= '0;
      else if (state == ST_RESET || state == ST_WAIT_LOCK) tmr <= tmr + 1'b1;
      stable_cnt <= (state == ST_WAIT_LOCK && state_nxt == ST_WAIT_LOCK && sup.cdr_locked)
                    ? stable_cnt + 1'b1 : '0;
    end
  end

  assign sup.state_o   = state;
  assign sup.retry_cnt = retry_q;

`ifdef SUP_STATS_EN
  logic retrain_evt;
  assign retrain_evt = (state == ST_ACTIVE) && (state_nxt == ST_RESET);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Saturating statistics; clear wins over a same-cycle increment
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sup.frames_ok  <= '0;
      sup.frames_err <= '0;
      sup.retrains   <= '0;
    end else if (sup.stats_clr) begin
      sup.frames_ok  <= '0;
      sup.frames_err <= '0;
      sup.retrains   <= '0;
    end else begin
      if (sup.rx_valid && !sup.frame_error) sup.frames_ok  <= sat_inc(sup.frames_ok);
      if (sup.rx_valid && sup.frame_error)  sup.frames_err <= sat_inc(sup.frames_err);
      if (retrain_evt)                      sup.retrains   <= sat_inc(sup.retrains);
    end
  end
`else
  logic stats_clr_unused;
  assign stats_clr_unused = sup.stats_clr;
  assign sup.frames_ok    = '0;
  assign sup.frames_err   = '0;
  assign sup.retrains     = '0;
`endif
endmodule
